// File: rtl/load_store_unit.sv
// Load/store stage for a word-wide data memory without byte enables.
// Sub-word stores are done as read-modify-write; busy stalls the core until done.
module load_store_unit #(
  parameter int ADDR_W       = 32,
  parameter bit SIGNED_LOADS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Handshake: mem_req is held with constant mem_addr/mem_we/mem_wdata until an
  // edge where mem_ack=1; that edge completes the request.
  state_t            state, state_n;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_we;
  logic              a_mis;
  logic [31:0]       a_wdata;
  logic [31:0]       a_word;

  logic        in_subword, in_mis;
  logic        l_byte, l_half;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [31:0] merged;

  assign in_subword = (size == 2'b01) || (size == 2'b10);
  assign in_mis     = ((size == 2'b10) && addr[0]) ||
                      (!in_subword && (addr[1:0] != 2'b00));
  assign l_byte     = (a_size == 2'b01);
  assign l_half     = (a_size == 2'b10);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (in_mis)                  state_n = DONE;
          else if (we && !in_subword)  state_n = WR;
          else                         state_n = RD;
        end
      end
      RD:   if (mem_ack) state_n = a_we ? WR : DONE;
      WR:   if (mem_ack) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_addr  <= '0;
      a_size  <= 2'b00;
      a_we    <= 1'b0;
      a_mis   <= 1'b0;
      a_wdata <= 32'h0;
      a_word  <= 32'h0;
    end else begin
      if (state == IDLE && req) begin
        a_addr  <= addr;
        a_size  <= size;
        a_we    <= we;
        a_mis   <= in_mis;
        a_wdata <= wdata;
      end
      if (state == RD && mem_ack) a_word <= mem_rdata;
    end
  end

  // Lane selection and extension for loads.
  always_comb begin
    byte_v = a_word[7:0];
    unique case (a_addr[1:0])
      2'd0: byte_v = a_word[7:0];
      2'd1: byte_v = a_word[15:8];
      2'd2: byte_v = a_word[23:16];
      2'd3: byte_v = a_word[31:24];
      default: byte_v = a_word[7:0];
    endcase
    half_v = a_addr[1] ? a_word[31:16] : a_word[15:0];
    if (l_byte)      load_v = {{24{SIGNED_LOADS && byte_v[7]}}, byte_v};
    else if (l_half) load_v = {{16{SIGNED_LOADS && half_v[15]}}, half_v};
    else             load_v = a_word;
  end

  // Write word: sub-word data merged into the word read back in RD.
  always_comb begin
    merged = a_word;
    if (l_byte) begin
      unique case (a_addr[1:0])
        2'd0: merged[7:0]   = a_wdata[7:0];
        2'd1: merged[15:8]  = a_wdata[7:0];
        2'd2: merged[23:16] = a_wdata[7:0];
        2'd3: merged[31:24] = a_wdata[7:0];
        default: merged = a_word;
      endcase
    end else if (l_half) begin
      if (a_addr[1]) merged[31:16] = a_wdata[15:0];
      else           merged[15:0]  = a_wdata[15:0];
    end else begin
      merged = a_wdata;
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    rdata     = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    unique case (state)
      IDLE: busy = req;
      RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {a_addr[ADDR_W-1:2], 2'b00};
      end
      WR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {a_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = merged;
      end
      DONE: begin
        done     = 1'b1;
        misalign = a_mis;
        if (!a_mis && !a_we) rdata = load_v;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage downstream of the immediate extender. It consumes the 2-bit MemorySelector access-size code, plus the computed address and store data, from the datapath.
- Performs word, halfword and byte loads and stores against a 32-bit word-wide data memory that has no byte enables. Sub-word stores therefore use a read-modify-write sequence.
- Stalls the processor with `busy` until the access completes.

Parameters:
- ADDR_W, 32, width of byte address from datapath.
- SIGNED_LOADS, 0, 0 = zero-extend sub-word loads; 1 = sign-extend.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  memory access requested (MemRead|MemWrite) this instruction.
- we  in  1  1 = store, 0 = load; valid with req.
- size  in  2  MemorySelector: 00 word, 01 byte, 10 halfword, 11 word.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data (sub-word data in low bits).
- rdata  out  32  load result, extended to 32 bits; valid while done=1.
- busy  out  1  stall processor.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  one-cycle pulse with done when the access was rejected.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  word address, low 2 bits forced 0.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read word, valid with mem_ack on a read.
- mem_ack  in  1  memory completes the current request at this edge.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset (sync, wins over everything, including mid-RD/WR):
  - state=IDLE; all outputs 0; internal latches 0.
  - Any outstanding memory request is abandoned; no write is issued after reset.
- Acceptance in IDLE when req=1:
  - addr, size, we and wdata are latched at the edge.
  - busy is combinational: 1 in IDLE&req, RD and WR; 0 in DONE.
- Misaligned accesses: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Next state is DONE with misalign=1 and rdata=0.
  - No mem_req is issued and memory is not modified.
- Transitions from IDLE:
  - Load → RD.
  - Word store → WR.
  - Byte/halfword store → RD.
- RD: mem_req=1, mem_we=0.
  - On an edge with mem_ack=1, capture mem_rdata.
  - Load → DONE; sub-word store → WR.
- WR: mem_req=1, mem_we=1, mem_wdata = merged word.
  - On mem_ack=1 → DONE.
- DONE: done=1, busy=0, rdata valid; next state IDLE unconditionally.
  - req is not sampled in DONE. The processor advances on this edge, and the next instruction's req is accepted in the following IDLE cycle.
- Inputs may change while busy; only the latched copies are used.
- Lane rules (little-endian):
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Byte store merges wdata[7:0] into bits [8*lane+7 : 8*lane] of the read word; the other bytes are unchanged.
  - Halfword store merges wdata[15:0] into bits [16*addr[1]+15 : 16*addr[1]].
  - Loads shift the captured word right by the lane, then zero- or sign-extend from bit 7 (byte) or bit 15 (halfword) according to SIGNED_LOADS.
- Latency with mem_ack held at 1 (cycles from req accepted in IDLE to done):
  - Word store: 2 (IDLE→WR→DONE).
  - Load: 2.
  - Sub-word store: 3.
  - Misaligned: 1.
  - Each cycle mem_ack is low adds one cycle.
- mem_addr, mem_we and mem_wdata are stable for as long as mem_req=1.
- Outputs during RD/WR: rdata=0, done=0, misalign=0.

Test Plan:
- Word store, then load: store addr=0x10, wdata=0xDEADBEEF, mem_ack tied 1.
  - Required: one WR with mem_addr=0x10, done 2 cycles after accept.
  - Load from 0x10 returns rdata=0xDEADBEEF.
- Byte store into memory word 0x11223344 at addr=0x22, wdata=0xAB.
  - Required: RD then WR with mem_wdata=0x11AB3344.
  - done 3 cycles after accept.
- Byte load at 0x23 of word 0x80FF0000.
  - SIGNED_LOADS=0: rdata=0x00000080.
  - SIGNED_LOADS=1: rdata=0xFFFFFF80.
- Halfword load at 0x02 of word 0xCAFE1234 → rdata=0x0000CAFE.
  - Halfword at 0x01 → misalign=1, rdata=0, and mem_req never asserted.
- Wait states: mem_ack low for 3 cycles during RD of a halfword store.
  - Required: busy=1 throughout and mem_addr stable.
  - WR starts on the cycle after ack.
- Reset asserted in WR with mem_ack=0.
  - Required: next cycle state=IDLE and all outputs 0.
  - A following req is accepted normally.
